lsu_store_bank_splitter: RTL and testbench

Parametrised store-path aligner between the LSU store stage and the byte-banked data memory. It replaces the fixed 2-bank odd/even write-data steering with N byte-wide banks. Each store is rotated onto bank lanes by its address, masked by its byte enables, and emitted over a registered valid/ready port. Stores that straddle a bank row are split into two back-to-back row writes.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_bank_rotator.sv | 43 ++++
 rtl/lsu_store_bank_splitter.sv | 151 +++++++++++++++
 tb/tb_lsu_store_bank_splitter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and geometry helpers for the LSU store bank splitter.
// Optional build macro LSU_SPLIT_TRAP_EN is consumed by lsu_store_bank_splitter.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W    = 32;
  localparam int unsigned LSU_NUM_BANKS = 4;
  localparam int unsigned LSU_ADDR_W    = 32;

  function automatic int unsigned row_w(input int unsigned aw,
                                        input int unsigned nb);
    return aw - $clog2(nb);
  endfunction

  function automatic int unsigned lane_cnt(input int unsigned dw);
    return dw / 8;
  endfunction

  localparam int unsigned ROW_W = row_w(LSU_ADDR_W, LSU_NUM_BANKS);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

  typedef struct packed {
    logic [ROW_W-1:0]           row;
    logic [LSU_NUM_BANKS-1:0]   we;
    logic [8*LSU_NUM_BANKS-1:0] wdata;
    logic                       last;
  } bank_beat_t;

endpackage

// File: rtl/lsu_bank_rotator.sv
// Rotates store lanes onto byte banks for a row offset and masks by byte enable.
// Produces the base-row beat (lo) and the next-row beat (hi) in one pass.
module lsu_bank_rotator
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned NUM_BANKS = LSU_NUM_BANKS,
  localparam int unsigned OFF_W    = $clog2(NUM_BANKS),
  localparam int unsigned LANES    = lane_cnt(DATA_W)
) (
  input  logic [OFF_W-1:0]       offset,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [LANES-1:0]       byte_en,
  output logic [NUM_BANKS-1:0]   lo_we,
  output logic [8*NUM_BANKS-1:0] lo_wdata,
  output logic [NUM_BANKS-1:0]   hi_we,
  output logic [8*NUM_BANKS-1:0] hi_wdata
);

  // steer each enabled lane to its bank; carry out of the offset picks the row
  always_comb begin
    lo_we    = '0;
    lo_wdata = '0;
    hi_we    = '0;
    hi_wdata = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      logic [OFF_W:0] pos;
      int             b;
      pos = {1'b0, offset} + (OFF_W+1)'(j);
      b   = int'(pos[OFF_W-1:0]);
      if (byte_en[j]) begin
        if (pos[OFF_W]) begin
          hi_we[b]          = 1'b1;
          hi_wdata[b*8 +: 8] = wdata[j*8 +: 8];
        end else begin
          lo_we[b]          = 1'b1;
          lo_wdata[b*8 +: 8] = wdata[j*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/lsu_store_bank_splitter.sv
// Store-path aligner onto N byte banks; row-straddling stores become two beats.
// Define LSU_SPLIT_TRAP_EN to trap straddling stores instead of splitting.
module lsu_store_bank_splitter
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned NUM_BANKS = LSU_NUM_BANKS,
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  localparam int unsigned OFF_W    = $clog2(NUM_BANKS),
  localparam int unsigned RW       = ADDR_W - OFF_W,
  localparam int unsigned LANES    = lane_cnt(DATA_W)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [DATA_W-1:0]      i_req_wdata,
  input  logic [LANES-1:0]       i_req_byte_en,
  output logic                   o_bank_valid,
  input  logic                   i_bank_ready,
  output logic [RW-1:0]          o_bank_row,
  output logic [NUM_BANKS-1:0]   o_bank_we,
  output logic [8*NUM_BANKS-1:0] o_bank_wdata,
  output logic                   o_bank_last,
  output logic                   o_misalign_err
);

  split_state_e state, state_n;
  bank_beat_t   out_q, out_n;
  bank_beat_t   beat_lo, beat_hi;
  logic         valid_q, valid_n;

  logic [NUM_BANKS-1:0]   lo_we, hi_we;
  logic [8*NUM_BANKS-1:0] lo_wdata, hi_wdata;
  logic [RW-1:0]          row0;
  logic                   split, active, fire, drain;

  assign row0 = i_req_addr[ADDR_W-1:OFF_W];

  lsu_bank_rotator #(
    .DATA_W    (DATA_W),
    .NUM_BANKS (NUM_BANKS)
  ) u_rot (
    .offset   (i_req_addr[OFF_W-1:0]),
    .wdata    (i_req_wdata),
    .byte_en  (i_req_byte_en),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata)
  );

  assign split  = |hi_we;
  assign active = |i_req_byte_en;

  assign beat_lo = '{row: row0, we: lo_we,
                     wdata: lo_wdata, last: !split};
  assign beat_hi = '{row: row0 + RW'(1), we: hi_we,
                     wdata: hi_wdata, last: 1'b1};

  assign o_req_ready = (state == IDLE)
                     && (!valid_q || i_bank_ready)
                     && !i_rst;
  assign fire  = i_req_valid && o_req_ready;
  assign drain = valid_q && i_bank_ready;

  assign o_bank_valid = valid_q;
  assign o_bank_row   = out_q.row;
  assign o_bank_we    = out_q.we;
  assign o_bank_wdata = out_q.wdata;
  assign o_bank_last  = out_q.last;

`ifdef LSU_SPLIT_TRAP_EN
  logic err_q, err_n;
  assign o_misalign_err = err_q;
`else
  bank_beat_t pend_q, pend_n;
  assign o_misalign_err = 1'b0;
`endif

  // next-state: retire drained beats, load new request, release held beat 2
  always_comb begin
    state_n = state;
    out_n   = out_q;
    valid_n = valid_q;
`ifdef LSU_SPLIT_TRAP_EN
    err_n   = 1'b0;
`else
    pend_n  = pend_q;
`endif
    if (drain) valid_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire && active) begin
`ifdef LSU_SPLIT_TRAP_EN
          if (split) begin
            err_n = 1'b1;
          end else begin
            out_n   = beat_lo;
            valid_n = 1'b1;
          end
`else
          out_n   = beat_lo;
          valid_n = 1'b1;
          if (split) begin
            pend_n  = beat_hi;
            state_n = SPLIT;
          end
`endif
        end
      end
      SPLIT: begin
`ifdef LSU_SPLIT_TRAP_EN
        state_n = IDLE;
`else
        if (drain) begin
          out_n   = pend_q;
          valid_n = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers; reset discards any pending beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef LSU_SPLIT_TRAP_EN
      err_q   <= 1'b0;
`else
      pend_q  <= '0;
`endif
    end else begin
      state   <= state_n;
      out_q   <= out_n;
      valid_q <= valid_n;
`ifdef LSU_SPLIT_TRAP_EN
      err_q   <= err_n;
`else
      pend_q  <= pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_store_bank_splitter.sv
// Randomised bench for lsu_store_bank_splitter (default build, 4 banks).
// Expected beats come from per-byte address arithmetic on a queue model.
module tb_lsu_store_bank_splitter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_byte_en;
  logic        o_bank_valid;
  logic        i_bank_ready;
  logic [29:0] o_bank_row;
  logic [3:0]  o_bank_we;
  logic [31:0] o_bank_wdata;
  logic        o_bank_last;
  logic        o_misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] row;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        last;
  } exp_beat_t;

  exp_beat_t q[$];

  always #5 clk = ~clk;

  lsu_store_bank_splitter dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .i_req_byte_en  (i_req_byte_en),
    .o_bank_valid   (o_bank_valid),
    .i_bank_ready   (i_bank_ready),
    .o_bank_row     (o_bank_row),
    .o_bank_we      (o_bank_we),
    .o_bank_wdata   (o_bank_wdata),
    .o_bank_last    (o_bank_last),
    .o_misalign_err (o_misalign_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: every enabled byte lands at absolute address A+j
  task automatic push_req(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  be);
    exp_beat_t b1, b2;
    logic [31:0] abs;
    logic [29:0] r0;
    r0 = a / 4;
    b1.row = r0;      b1.we = 0; b1.wdata = 0;
    b2.row = r0 + 1;  b2.we = 0; b2.wdata = 0;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) begin
        abs = a + j;
        if (abs[31:2] == r0) begin
          b1.we[abs % 4] = 1'b1;
          b1.wdata[(abs % 4)*8 +: 8] = d[j*8 +: 8];
        end else begin
          b2.we[abs % 4] = 1'b1;
          b2.wdata[(abs % 4)*8 +: 8] = d[j*8 +: 8];
        end
      end
    end
    if (be == 0) return;
    b1.last = (b2.we == 0);
    b2.last = 1'b1;
    q.push_back(b1);
    if (b2.we != 0) q.push_back(b2);
  endtask

  task automatic step(input logic        v,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  be,
                      input logic        br);
    logic exp_rdy;
    @(negedge clk);
    i_req_valid   = v;
    i_req_addr    = a;
    i_req_wdata   = d;
    i_req_byte_en = be;
    i_bank_ready  = br;
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && br);
    check("bank_valid", 64'(o_bank_valid), 64'(q.size() > 0));
    check("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    check("misalign", 64'(o_misalign_err), 64'(0));
    if (q.size() > 0) begin
      check("row", 64'(o_bank_row), 64'(q[0].row));
      check("we", 64'(o_bank_we), 64'(q[0].we));
      check("wdata", 64'(o_bank_wdata), 64'(q[0].wdata));
      check("last", 64'(o_bank_last), 64'(q[0].last));
      if (br) void'(q.pop_front());
    end
    if (v && o_req_ready) push_req(a, d, be);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(o_bank_valid), 64'(0));
    check({tag, "_we"}, 64'(o_bank_we), 64'(0));
    check({tag, "_wdata"}, 64'(o_bank_wdata), 64'(0));
    check({tag, "_row"}, 64'(o_bank_row), 64'(0));
    check({tag, "_last"}, 64'(o_bank_last), 64'(0));
    check({tag, "_err"}, 64'(o_misalign_err), 64'(0));
  endtask

  initial begin
    logic [31:0] a;
    int guard;
    i_rst = 1'b1;
    i_req_valid = 0; i_req_addr = 0; i_req_wdata = 0;
    i_req_byte_en = 0; i_bank_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("rst");
    check("rst_ready", 64'(o_req_ready), 64'(0));
    @(negedge clk);
    i_rst = 1'b0;

    // directed cases from the plan
    step(1, 32'h100, 32'hDDCCBBAA, 4'hF, 1);
    step(1, 32'h103, 32'h0000BBAA, 4'h3, 1);
    step(0, 0, 0, 0, 1);
    step(1, 32'h103, 32'h000000AA, 4'h1, 1);
    step(1, 32'hFFFFFFFE, 32'h44332211, 4'hF, 1);
    step(0, 0, 0, 0, 1);
    step(1, 32'h200, 32'h12345678, 4'h0, 1);
    step(0, 0, 0, 0, 1);

    // stall beat 1 for three cycles then release
    step(1, 32'h102, 32'hA1B2C3D4, 4'hF, 0);
    step(1, 32'h500, 32'h1, 4'hF, 0);
    step(1, 32'h500, 32'h1, 4'hF, 0);
    step(1, 32'h500, 32'h1, 4'hF, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // reset while holding a split
    step(1, 32'h10F, 32'hCAFEF00D, 4'hF, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    i_rst = 1'b1;
    i_req_valid = 1'b1;
    i_bank_ready = 1'b0;
    #1;
    check("rst_hold_ready", 64'(o_req_ready), 64'(0));
    @(negedge clk);
    #1;
    check_zero("midrst");
    i_rst = 1'b0;
    i_req_valid = 1'b0;
    i_bank_ready = 1'b1;
    q.delete();
    #1;
    check("post_rst_ready", 64'(o_req_ready), 64'(1));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // random traffic, some addresses near the wrap point
    for (int n = 0; n < 3000; n++) begin
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7), a, $urandom,
           4'($urandom), ($urandom_range(0, 3) != 0));
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    check("drained", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
